// File: rtl/adaptive_binarization.sv
// Per-pixel luma binarisation with fixed, register, frame-mean or hysteresis threshold.
// The frame mean comes from a restoring divider that runs between frames.
module adaptive_binarization #(
   parameter int unsigned DW         = 8,
   parameter int unsigned DEF_THRESH = 220,
   parameter int unsigned CNT_W      = 21,
   parameter int unsigned HYST       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ycbcr_vsync,
   input  logic          ycbcr_href,
   input  logic          ycbcr_de,
   input  logic [DW-1:0] luminance,
   input  logic [1:0]    cfg_mode,
   input  logic [DW-1:0] cfg_thresh,
   input  logic [DW:0]   cfg_offset,
   input  logic          cfg_invert,
   output logic          post_vsync,
   output logic          post_href,
   output logic          post_de,
   output logic          monoc,
   output logic [DW-1:0] cur_thresh,
   output logic          mean_valid
);

   localparam int unsigned SUM_W = DW + CNT_W;
   localparam int unsigned BC_W  = $clog2(SUM_W);
   localparam logic [DW-1:0] DEF_T = DW'(DEF_THRESH);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t r_state, w_state_nxt;
   logic   w_div_load;

   logic             r_vs_d, r_href_d, r_de_d, r_monoc;
   logic [DW-1:0]    r_thresh, r_mean;
   logic [1:0]       r_mode;
   logic             r_inv, r_hyst, r_mean_valid;
   logic [SUM_W-1:0] r_sum, r_quo;
   logic [CNT_W-1:0] r_cnt, r_dvs, r_rem;
   logic [BC_W-1:0]  r_bit_cnt;

   logic w_frame_start, w_frame_end, w_pix, w_de_rise;
   assign w_frame_start = ycbcr_vsync & ~r_vs_d;
   assign w_frame_end   = ~ycbcr_vsync & r_vs_d;
   assign w_pix         = ycbcr_vsync & ycbcr_de;
   assign w_de_rise     = ycbcr_de & ~r_de_d;

   // Threshold to load at frame start
   logic signed [DW+1:0] w_adj;
   logic [DW-1:0]        w_t_load;
   assign w_adj = $signed({2'b00, r_mean}) + $signed({cfg_offset[DW], cfg_offset});

   always_comb begin
      w_t_load = DEF_T;
      case (cfg_mode)
         2'd1, 2'd3: w_t_load = cfg_thresh;
         2'd2: begin
            if (r_mean_valid) begin
               if (w_adj[DW+1])    w_t_load = '0;
               else if (w_adj[DW]) w_t_load = '1;
               else                w_t_load = w_adj[DW-1:0];
            end
         end
         default: w_t_load = DEF_T;
      endcase
   end

   // The frame-start cycle already uses the freshly sampled configuration
   logic [DW-1:0] w_t, w_hi, w_lo;
   logic [DW:0]   w_hi_sum;
   logic [1:0]    w_mode;
   logic          w_inv, w_prev, w_raw;
   assign w_t      = w_frame_start ? w_t_load   : r_thresh;
   assign w_mode   = w_frame_start ? cfg_mode   : r_mode;
   assign w_inv    = w_frame_start ? cfg_invert : r_inv;
   assign w_hi_sum = {1'b0, w_t} + (DW+1)'(HYST);
   assign w_hi     = w_hi_sum[DW] ? '1 : w_hi_sum[DW-1:0];
   assign w_lo     = (w_t < DW'(HYST)) ? '0 : w_t - DW'(HYST);
   assign w_prev   = w_de_rise ? 1'b0 : r_hyst;

   always_comb begin
      w_raw = (luminance > w_t);
      if (w_mode == 2'd3) begin
         if (luminance > w_hi)      w_raw = 1'b1;
         else if (luminance < w_lo) w_raw = 1'b0;
         else                       w_raw = w_prev;
      end
   end

   // Video pipeline, frame configuration and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_d   <= 1'b0;
         r_href_d <= 1'b0;
         r_de_d   <= 1'b0;
         r_monoc  <= 1'b0;
         r_thresh <= DEF_T;
         r_mode   <= 2'd0;
         r_inv    <= 1'b0;
         r_hyst   <= 1'b0;
         r_sum    <= '0;
         r_cnt    <= '0;
      end else begin
         r_vs_d   <= ycbcr_vsync;
         r_href_d <= ycbcr_href;
         r_de_d   <= ycbcr_de;
         r_monoc  <= w_pix & (w_raw ^ w_inv);
         if (w_pix) r_hyst <= w_raw;
         if (w_frame_start) begin
            r_thresh <= w_t_load;
            r_mode   <= cfg_mode;
            r_inv    <= cfg_invert;
            r_sum    <= w_pix ? SUM_W'(luminance) : '0;
            r_cnt    <= w_pix ? CNT_W'(1) : '0;
         end else if (w_pix && (r_cnt != '1)) begin
            r_sum <= r_sum + SUM_W'(luminance);
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_div_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_frame_end && (r_cnt != '0)) begin
               w_div_load  = 1'b1;
               w_state_nxt = S_DIV;
            end
         end
         S_DIV:   if (r_bit_cnt == '0) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Restoring divider: dividend shifts out of r_quo while quotient bits shift in
   logic [CNT_W:0] w_rem_sh;
   logic           w_qbit;
   assign w_rem_sh = {r_rem, r_quo[SUM_W-1]};
   assign w_qbit   = (w_rem_sh >= {1'b0, r_dvs});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_quo        <= '0;
         r_dvs        <= '0;
         r_rem        <= '0;
         r_bit_cnt    <= '0;
         r_mean       <= DEF_T;
         r_mean_valid <= 1'b0;
      end else begin
         if (w_div_load) begin
            r_quo     <= r_sum;
            r_dvs     <= r_cnt;
            r_rem     <= '0;
            r_bit_cnt <= BC_W'(SUM_W - 1);
         end else if (r_state == S_DIV) begin
            r_quo     <= {r_quo[SUM_W-2:0], w_qbit};
            r_rem     <= w_qbit ? CNT_W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[CNT_W-1:0];
            r_bit_cnt <= r_bit_cnt - BC_W'(1);
         end
         if (r_state == S_DONE) begin
            r_mean       <= (|r_quo[SUM_W-1:DW]) ? '1 : r_quo[DW-1:0];
            r_mean_valid <= 1'b1;
         end
      end
   end

   assign post_vsync = r_vs_d;
   assign post_href  = r_href_d;
   assign post_de    = r_de_d;
   assign monoc      = r_monoc;
   assign cur_thresh = r_thresh;
   assign mean_valid = r_mean_valid;

endmodule

// File: doc/adaptive_binarization.md
ADAPTIVE_BINARIZATION -- requirements
Module: adaptive_binarization

Interface
REQ-001 SHALL have parameter DW, 8: luminance and threshold width.
REQ-002 SHALL have parameter DEF_THRESH, 220: mode-0 threshold and reset value of the active threshold.
REQ-003 SHALL have parameter CNT_W, 21: pixel-counter width; SUM_W = DW+CNT_W.
REQ-004 SHALL have parameter HYST, 8: mode-3 half-band, unsigned, DW bits.
REQ-005 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port ycbcr_vsync  in  1  frame-active window, high during the frame.
REQ-008 SHALL have ports ycbcr_href and ycbcr_de  in  1 each  line-valid and pixel-valid.
REQ-009 SHALL have port luminance  in  DW  pixel luma, valid when ycbcr_de=1.
REQ-010 SHALL have port cfg_mode  in  2  mode: 0 fixed, 1 register, 2 adaptive mean, 3 hysteresis.
REQ-011 SHALL have ports cfg_thresh  in  DW and cfg_offset  in  DW+1 (signed, two's complement).
REQ-012 SHALL have port cfg_invert  in  1  which inverts monoc when high.
REQ-013 SHALL have ports post_vsync, post_href, post_de  out  1 each  inputs delayed one clock.
REQ-014 SHALL have port monoc  out  1  binary pixel, 1 = white.
REQ-015 SHALL have ports cur_thresh  out  DW (active threshold) and mean_valid  out  1 (a mean was latched since reset).

Function
REQ-016 SHALL register post_vsync/post_href/post_de and monoc with exactly 1-clock latency.
REQ-017 SHALL force monoc=0 on the cycle after any input cycle with ycbcr_de=0 or ycbcr_vsync=0; cfg_invert SHALL NOT apply on such cycles.
REQ-018 SHALL sample cfg_mode, cfg_thresh, cfg_offset and cfg_invert only on a vsync rising edge (frame start); the sampled values hold for the whole frame.
REQ-019 SHALL load the active threshold T at frame start: mode 0 -> DEF_THRESH; modes 1 and 3 -> cfg_thresh; mode 2 -> clamp(mean_reg + cfg_offset, 0, 2^DW-1).
REQ-020 In mode 2 with mean_valid=0, T SHALL be DEF_THRESH.
REQ-021 In modes 0-2, monoc SHALL be (luminance > T) XOR invert, using a strictly-greater comparison.
REQ-022 In mode 3, the raw result SHALL be 1 if luminance > T+HYST, 0 if luminance < T-HYST, and otherwise the previous raw value on that line; the bounds SHALL saturate at 2^DW-1 and 0; the previous value SHALL be cleared to 0 on each de rising edge; invert SHALL apply after this.
REQ-023 Every frame, in all modes, SHALL accumulate luminance into an SUM_W-bit sum and count de pixels in a CNT_W-bit counter; both SHALL clear at frame start; the counter SHALL saturate at all-ones, and the sum SHALL stop accumulating once the counter saturates.
REQ-024 The divider FSM SHALL have states IDLE, DIV, DONE; on a vsync falling edge it SHALL go IDLE->DIV with snapshots of sum and count.
REQ-025 DIV SHALL compute floor(sum/count) by restoring division, one quotient bit per clock, finishing in at most SUM_W clocks, then go to DONE.
REQ-026 DONE SHALL write mean_reg (the quotient saturated to 2^DW-1), set mean_valid=1, and return to IDLE after 1 clock.
REQ-027 If count=0 at frame end, the FSM SHALL skip DIV, and mean_reg and mean_valid SHALL remain unchanged.
REQ-028 If a vsync rising edge occurs while the FSM is in DIV, T SHALL use the old mean_reg for that frame; the division SHALL complete, and its result SHALL apply at the next frame start.
REQ-029 A vsync falling edge while in DIV SHALL be ignored.
REQ-030 cur_thresh SHALL equal T at all times.

Reset
REQ-031 rst_n low SHALL asynchronously set: all post_* outputs, monoc and mean_valid to 0; cur_thresh and mean_reg to DEF_THRESH; sum and count to 0; the FSM to IDLE; the sampled cfg to mode 0 with invert 0.
REQ-032 Reset asserted mid-frame or mid-division SHALL discard the partial sum and the partial quotient.
REQ-033 After reset release, the first vsync rising edge SHALL be treated as frame start; a frame already in progress at release SHALL be accumulated but SHALL NOT produce a mean until its falling edge.

Verification
REQ-034 Mode 0, DW=8: pixels 220, 221, 0, 255 with de=1 -> monoc 0, 1, 0, 1, each 1 clock after its pixel; post_de mirrors de delayed by 1.
REQ-035 Mode 1, cfg_thresh=100, cfg_invert=1: pixel 101 -> 0; pixel 100 -> 1; a de=0 gap -> 0; cfg_thresh changed to 50 mid-frame -> no effect until the next frame.
REQ-036 Mode 2: a 4x4 frame of all 60 -> mean_reg=60 and mean_valid=1 within SUM_W+2 clocks of the frame end; the next frame with cfg_offset=-10 gives cur_thresh=50; cfg_offset=+250 with mean 60 -> cur_thresh=255 (clamped).
REQ-037 Mode 3, T=128, HYST=8: line sequence 130, 137, 125, 119, 125 -> raw 0, 1, 1, 0, 0; the next line starting at 130 -> 0.
REQ-038 Edge cases: a frame with de never high -> mean unchanged; a vsync rising edge 3 clocks after the frame end (DIV busy) -> old T retained, new mean applied the frame after; rst_n pulsed during DIV -> mean_valid=0 and cur_thresh=220.
